button_event_gen: RTL and testbench
===================================

Name: button_event_gen

Overview:
- Consumes the debounced button level and turns it into single-cycle UI events: press, release, long-press and auto-repeat.
- Sits directly downstream of the button debouncer. Feeds the GPU command/menu logic, which only ever sees clean one-clock strobes.
- Timing runs off an external tick strobe (e.g. vsync or a ms prescaler), so hold times are independent of clk frequency.

Parameters:
- CNT_W, 8, width of the internal hold/repeat counter.
- LONG_TICKS, 8'd60, ticks the button must stay held after press before long_pulse (legal range 1..2^CNT_W-1).
- REPEAT_TICKS, 8'd10, ticks between successive repeat_pulse in LONG state (legal range 1..2^CNT_W-1).
- REPEAT_EN, 1'b1, 1 enables auto-repeat; 0 suppresses repeat_pulse entirely.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- tick  input  1  time-base strobe, one clk wide, any rate (may be tied high).
- btn_level  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- press_pulse  output  1  one-cycle strobe on press.
- release_pulse  output  1  one-cycle strobe on release.
- long_pulse  output  1  one-cycle strobe when hold reaches LONG_TICKS.
- repeat_pulse  output  1  one-cycle strobe every REPEAT_TICKS while in long hold.
- held  output  1  level, 1 while the FSM is not in IDLE.
- is_long  output  1  level, 1 while in LONG state.

Behaviour:
- All outputs registered.
- Reset (rst_n low, async): state=IDLE, counter=0, all six outputs 0. Reset asserted mid-hold aborts silently; no release_pulse is generated.
- FSM states: IDLE, PRESS, LONG. All pulse outputs default 0 every cycle unless set below.
- IDLE:
  - If btn_level=1 at a clk edge: press_pulse=1 for the following cycle, counter<=0, state<=PRESS.
  - tick is ignored in IDLE.
  - A button held across reset deassertion produces press_pulse on the first edge after rst_n rises.
- PRESS:
  - If btn_level=0: release_pulse=1, state<=IDLE, counter<=0.
  - Else if tick=1 and counter==LONG_TICKS-1: long_pulse=1, counter<=0, state<=LONG.
  - Else if tick=1: counter<=counter+1.
  - Else hold.
- LONG:
  - If btn_level=0: release_pulse=1, state<=IDLE, counter<=0.
  - Else if REPEAT_EN and tick=1 and counter==REPEAT_TICKS-1: repeat_pulse=1, counter<=0.
  - Else if REPEAT_EN and tick=1: counter<=counter+1.
  - With REPEAT_EN=0 the counter stays 0.
- Latency: btn_level to press_pulse/release_pulse is 1 clk. The qualifying tick to long_pulse/repeat_pulse is 1 clk.
- Simultaneous events: btn_level=0 together with a qualifying tick gives release_pulse only; long/repeat is dropped.
- At most one pulse output high in any cycle; pulses are mutually exclusive by construction.
- held=1 in PRESS and LONG. is_long=1 in LONG only. Both change on the same edge as the state register.
- Counter width CNT_W; arithmetic is unsigned. Counter never wraps: it is cleared at terminal count, and parameters must be below 2^CNT_W.
- tick held permanently high makes every clk a tick (used for fast sim).
- A short press (release before LONG_TICKS ticks) yields press then release only.

Test Plan:
- Reset/idle: rst_n low with btn_level=1, then high -> all outputs 0 during reset; press_pulse on first edge after release; held=1 next cycle.
- Short press (LONG_TICKS=4, tick every 4 clks): btn high for 10 clks -> exactly one press_pulse, one release_pulse 1 clk after btn falls; no long_pulse; held back to 0.
- Long + repeat (LONG_TICKS=4, REPEAT_TICKS=2, tick tied high): btn high 12 clks -> press at cycle 1, long_pulse 4 clks later, repeat_pulse every 2 clks thereafter (3 repeats), then release_pulse; is_long high from long_pulse to release.
- REPEAT_EN=0, same stimulus -> long_pulse once, zero repeat_pulse, release_pulse on fall.
- Simultaneous: btn falls on the same edge as the 4th tick in PRESS -> release_pulse only, no long_pulse; also rst_n asserted mid-LONG -> outputs 0 immediately, no release_pulse.
- Random btn/tick soak (10k clks): assert pulses mutually exclusive and one-cycle; press/release counts differ by at most 1; long_pulse never without a preceding press.

Source files
------------

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_gen
//  Description : Turns a debounced button level into one-clock UI strobes:
//                press, release, long-press and auto-repeat. Hold timing is
//                measured in external tick strobes, not clk cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_gen #(
    parameter int               CNT_W        = 8,
    parameter logic [CNT_W-1:0] LONG_TICKS   = 8'd60,
    parameter logic [CNT_W-1:0] REPEAT_TICKS = 8'd10,
    parameter bit               REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held,
    output logic is_long
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PRESS = 2'd1;
    localparam logic [1:0] c_LONG  = 2'd2;

    // Terminal counts: the counter runs 0..N-1 and is cleared on the N-th tick.
    localparam logic [CNT_W-1:0] c_LONG_LAST   = LONG_TICKS - 1'b1;
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = REPEAT_TICKS - 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic             r_is_long;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_release;
    logic             w_long;
    logic             w_repeat;

    // Next-state, counter and pulse decode; release always wins over tick events.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (btn_level) begin
                    w_press     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_PRESS;
                end
            end
            c_PRESS: begin
                if (!btn_level) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_IDLE;
                end else if (tick && (r_cnt == c_LONG_LAST)) begin
                    w_long      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_LONG;
                end else if (tick) begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_LONG: begin
                if (!btn_level) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_IDLE;
                end else if (REPEAT_EN && tick && (r_cnt == c_REPEAT_LAST)) begin
                    w_repeat    = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (REPEAT_EN && tick) begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and all outputs registered together; reset aborts silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
            r_is_long <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= (w_state_nxt != c_IDLE);
            r_is_long <= (w_state_nxt == c_LONG);
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign held          = r_held;
    assign is_long       = r_is_long;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_gen
//  Description : Self-checking bench for button_event_gen. Two instances
//                (auto-repeat on/off) share stimulus and are compared each
//                cycle against a tick-counting reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

    localparam int L = 4;
    localparam int R = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic btn_level = 1'b0;

    logic a_press, a_release, a_long, a_repeat, a_held, a_is_long;
    logic b_press, b_release, b_long, b_repeat, b_held, b_is_long;
    logic [5:0] a_obs;
    logic [5:0] b_obs;

    assign a_obs = {a_press, a_release, a_long, a_repeat, a_held, a_is_long};
    assign b_obs = {b_press, b_release, b_long, b_repeat, b_held, b_is_long};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: active hold flag and ticks counted since press.
    bit         m_act[2];
    int         m_n[2];
    logic [5:0] m_exp[2];
    int         pcnt[2];
    int         rcnt[2];
    bit         seen_press[2];

    always #5 clk = ~clk;

    button_event_gen #(
        .CNT_W(8), .LONG_TICKS(8'd4), .REPEAT_TICKS(8'd2), .REPEAT_EN(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_level(btn_level),
        .press_pulse(a_press), .release_pulse(a_release), .long_pulse(a_long),
        .repeat_pulse(a_repeat), .held(a_held), .is_long(a_is_long)
    );

    button_event_gen #(
        .CNT_W(8), .LONG_TICKS(8'd4), .REPEAT_TICKS(8'd2), .REPEAT_EN(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_level(btn_level),
        .press_pulse(b_press), .release_pulse(b_release), .long_pulse(b_long),
        .repeat_pulse(b_repeat), .held(b_held), .is_long(b_is_long)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs from the rules: long at the L-th tick of the hold,
    // repeat at every R-th tick after that, release overrides everything.
    task automatic model_step(input int k, input bit en, input bit r, input bit b, input bit t);
        bit p  = 1'b0;
        bit rl = 1'b0;
        bit lg = 1'b0;
        bit rp = 1'b0;
        if (!r) begin
            m_act[k] = 1'b0;
            m_n[k]   = 0;
        end else if (!m_act[k]) begin
            if (b) begin
                p        = 1'b1;
                m_act[k] = 1'b1;
                m_n[k]   = 0;
            end
        end else if (!b) begin
            rl       = 1'b1;
            m_act[k] = 1'b0;
            m_n[k]   = 0;
        end else if (t) begin
            m_n[k]++;
            if (m_n[k] == L)
                lg = 1'b1;
            else if (en && m_n[k] > L && ((m_n[k] - L) % R) == 0)
                rp = 1'b1;
        end
        m_exp[k] = {p, rl, lg, rp, m_act[k], (m_act[k] && m_n[k] >= L)};
    endtask

    task automatic check_all(input bit r);
        logic [5:0] o;
        for (int k = 0; k < 2; k++) begin
            o = (k == 0) ? a_obs : b_obs;
            chk((k == 0) ? "dutA_outputs" : "dutB_outputs", {26'd0, o}, {26'd0, m_exp[k]});
            chk((k == 0) ? "dutA_onehot" : "dutB_onehot", {31'd0, ($countones(o[5:2]) <= 1)}, 32'd1);
            if (!r) begin
                pcnt[k] = 0;
                rcnt[k] = 0;
                seen_press[k] = 1'b0;
            end else begin
                if (o[5]) begin pcnt[k]++; seen_press[k] = 1'b1; end
                if (o[3]) chk((k == 0) ? "dutA_long_after_press" : "dutB_long_after_press",
                              {31'd0, seen_press[k]}, 32'd1);
                if (o[4]) begin rcnt[k]++; seen_press[k] = 1'b0; end
                chk((k == 0) ? "dutA_press_release_balance" : "dutB_press_release_balance",
                    {31'd0, ((pcnt[k] - rcnt[k]) == 0 || (pcnt[k] - rcnt[k]) == 1)}, 32'd1);
            end
        end
    endtask

    task automatic cycle(input bit r, input bit b, input bit t);
        @(negedge clk);
        rst_n     = r;
        btn_level = b;
        tick      = t;
        @(posedge clk);
        model_step(0, 1'b1, r, b, t);
        model_step(1, 1'b0, r, b, t);
        #1;
        check_all(r);
    endtask

    initial begin
        bit b;
        bit t_hi;
        // Reset with the button already held: silent, then press on first edge.
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Short press with a tick every 4 clks: never reaches long.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, (i % 4) == 3);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        // Long hold with tick tied high: long then repeats (instance A only).
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b1);

        // Release on the same edge as the long-qualifying tick.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-LONG: outputs clear at once, no release.
        repeat (8) cycle(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_step(0, 1'b1, 1'b0, 1'b1, 1'b1);
        model_step(1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_all(1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);

        // Random soak: slowly varying button, mixed tick density, rare resets.
        b    = 1'b0;
        t_hi = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0) b = ~b;
            if ($urandom_range(499) == 0) t_hi = ~t_hi;
            cycle(($urandom_range(1999) != 0), b, t_hi | ($urandom_range(3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
